// File: rtl/alu_muldiv_seq_pkg.sv
// Shared CPU encodings: ALU function codes, mul/div op select and the
// sequencer state encoding.
package alu_muldiv_seq_pkg;
  localparam logic [2:0] ALU_AND     = 3'h0;
  localparam logic [2:0] ALU_OR      = 3'h1;
  localparam logic [2:0] ALU_ADD     = 3'h2;
  localparam logic [2:0] ALU_SUB     = 3'h3;
  localparam logic [2:0] ALU_LSHIFT  = 3'h4;
  localparam logic [2:0] ALU_RSHIFTA = 3'h5;
  localparam logic [2:0] ALU_RSHIFTL = 3'h6;
  localparam logic [2:0] ALU_XOR     = 3'h7;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/alu_muldiv_seq.sv
// Unsigned shift-add multiply / restoring divide that borrows the shared ALU
// for one add or subtract per cycle; all shifting stays in local registers.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dz_o,
  output logic [WIDTH-1:0] alu_in1_o,
  output logic [WIDTH-1:0] alu_in2_o,
  output logic [2:0]       alu_func_o,
  output logic             alu_c_in_o,
  input  logic [WIDTH-1:0] alu_out_i
);
  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             op_q;
  logic [CW-1:0]    cnt_q;
  // hi_acc/lo_acc hold product-hi/multiplier for MUL, remainder/dividend for DIV
  logic [WIDTH-1:0] hi_acc, lo_acc, mcand;
  logic [WIDTH-1:0] shifted, nxt_hi, nxt_lo;
  logic             top, carry, borrow, ok, accept, div_zero;

  assign shifted  = {hi_acc[WIDTH-2:0], lo_acc[WIDTH-1]};
  assign top      = hi_acc[WIDTH-1];
  assign div_zero = (op_i == OP_DIV) && (b_i == '0);
  assign accept   = (state_q == S_IDLE) && start_i && !abort_i;

  assign ready_o    = (state_q == S_IDLE);
  assign done_o     = (state_q == S_DONE) && !abort_i;
  assign alu_c_in_o = 1'b0;

  always_comb begin
    alu_in1_o  = '0;
    alu_in2_o  = '0;
    alu_func_o = ALU_ADD;
    if (state_q == S_RUN) begin
      if (op_q == OP_MUL) begin
        alu_in1_o = hi_acc;
        alu_in2_o = lo_acc[0] ? mcand : '0;
      end else begin
        alu_in1_o  = shifted;
        alu_in2_o  = mcand;
        alu_func_o = ALU_SUB;
      end
    end
  end

  // Carry/borrow recovered from operand and result sign bits
  assign carry  = (alu_in1_o[WIDTH-1] & alu_in2_o[WIDTH-1]) |
                  ((alu_in1_o[WIDTH-1] | alu_in2_o[WIDTH-1]) & ~alu_out_i[WIDTH-1]);
  assign borrow = (~alu_in1_o[WIDTH-1] & alu_in2_o[WIDTH-1]) |
                  ((~alu_in1_o[WIDTH-1] | alu_in2_o[WIDTH-1]) & alu_out_i[WIDTH-1]);
  assign ok     = top | ~borrow;

  always_comb begin
    if (op_q == OP_MUL) begin
      nxt_hi = {carry, alu_out_i[WIDTH-1:1]};
      nxt_lo = {alu_out_i[0], lo_acc[WIDTH-1:1]};
    end else begin
      nxt_hi = ok ? alu_out_i : shifted;
      nxt_lo = {lo_acc[WIDTH-2:0], ok};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = div_zero ? S_DONE : S_RUN;
      S_RUN: begin
        if (abort_i)           state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      hi_acc  <= '0;
      lo_acc  <= '0;
      mcand   <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
      dz_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op_i;
        cnt_q  <= CW'(WIDTH - 1);
        hi_acc <= '0;
        lo_acc <= a_i;
        mcand  <= b_i;
        dz_o   <= div_zero;
        if (div_zero) begin
          hi_o <= a_i;
          lo_o <= '1;
        end
      end else if (state_q == S_RUN && !abort_i) begin
        hi_acc <= nxt_hi;
        lo_acc <= nxt_lo;
        cnt_q  <= cnt_q - CW'(1);
        if (cnt_q == '0) begin
          hi_o <= nxt_hi;
          lo_o <= nxt_lo;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomised scoreboard bench for alu_muldiv_seq with a behavioural ALU
// closing the loop; expected results come from plain 64-bit arithmetic.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;
  localparam int W  = 32;
  localparam int SW = $clog2(W);

  logic         clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, op_i = 1'b0, abort_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         ready_o, done_o, dz_o, alu_c_in_o;
  logic [W-1:0] hi_o, lo_o, alu_in1_o, alu_in2_o, alu_out_i;
  logic [2:0]   alu_func_o;

  always #5 clk_i = ~clk_i;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .abort_i(abort_i), .ready_o(ready_o),
    .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o), .dz_o(dz_o),
    .alu_in1_o(alu_in1_o), .alu_in2_o(alu_in2_o), .alu_func_o(alu_func_o),
    .alu_c_in_o(alu_c_in_o), .alu_out_i(alu_out_i)
  );

  always_comb begin
    case (alu_func_o)
      ALU_AND:     alu_out_i = alu_in1_o & alu_in2_o;
      ALU_OR:      alu_out_i = alu_in1_o | alu_in2_o;
      ALU_ADD:     alu_out_i = alu_in1_o + alu_in2_o + W'(alu_c_in_o);
      ALU_SUB:     alu_out_i = alu_in1_o - alu_in2_o;
      ALU_LSHIFT:  alu_out_i = alu_in1_o << alu_in2_o[SW-1:0];
      ALU_RSHIFTA: alu_out_i = $unsigned($signed(alu_in1_o) >>> alu_in2_o[SW-1:0]);
      ALU_RSHIFTL: alu_out_i = alu_in1_o >> alu_in2_o[SW-1:0];
      default:     alu_out_i = alu_in1_o ^ alu_in2_o;
    endcase
  end

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_cmp = 0, n_bad = 0;
  int           cyc = 0;
  logic         cur_op = 1'b0;
  logic [W-1:0] cur_b = '0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: condition not met (t=%0t)", name, $time);
  endtask

  // Reference result; a done seen at the negedge after edge accept+lat-1
  function automatic exp_t model(input logic op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int acc);
    exp_t        e;
    logic [63:0] p;
    e.dz = 1'b0;
    if (op == OP_MUL) begin
      p    = 64'(a) * 64'(b);
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.cyc = acc + W;
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
      e.cyc = acc;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
      e.cyc = acc + W;
    end
    return e;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      check("c_in_zero", 64'(alu_c_in_o), 64'd0);
      if (done_o) begin
        if (sb.size() == 0) fail("unexpected_done");
        else begin
          mon_e = sb.pop_front();
          check("hi", 64'(hi_o), 64'(mon_e.hi));
          check("lo", 64'(lo_o), 64'(mon_e.lo));
          check("dz", 64'(dz_o), 64'(mon_e.dz));
          check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          last_hi = mon_e.hi;
          last_lo = mon_e.lo;
        end
      end else if (ready_o) begin
        check("idle_in1", 64'(alu_in1_o), 64'd0);
        check("idle_in2", 64'(alu_in2_o), 64'd0);
        check("idle_func", 64'(alu_func_o), 64'(ALU_ADD));
      end else if (cur_op == OP_MUL) begin
        check("mul_func", 64'(alu_func_o), 64'(ALU_ADD));
      end else begin
        check("div_func", 64'(alu_func_o), 64'(ALU_SUB));
        check("div_in2", 64'(alu_in2_o), 64'(cur_b));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o) begin
      @(posedge clk_i); #1;
      n++;
      if (n > 200) begin
        fail("ready_timeout");
        break;
      end
    end
  endtask

  // Drives one start; push=0 marks operations that will be aborted or reset
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    wait_ready();
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    cur_op = op; cur_b = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    if (push) sb.push_back(model(op, a, b, cyc));
  endtask

  task automatic check_reset_vals();
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_dz", 64'(dz_o), 64'd0);
    check("rst_in1", 64'(alu_in1_o), 64'd0);
    check("rst_in2", 64'(alu_in2_o), 64'd0);
    check("rst_func", 64'(alu_func_o), 64'(ALU_ADD));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rop;
    #2;
    check_reset_vals();
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(OP_DIV, 32'd100, 32'd7, 1'b1);
    issue(OP_DIV, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
    issue(OP_DIV, 32'h1234_5678, 32'h0, 1'b1);

    // Extra start pulses while busy must be ignored
    issue(OP_MUL, 32'd3, 32'd5, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      if (k == 5 || k == 10) begin
        start_i = 1'b1; op_i = OP_DIV; a_i = $urandom; b_i = $urandom;
      end else start_i = 1'b0;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;

    for (int i = 0; i < 30; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = 32'h8000_0000 | $urandom;
        default: rb = $urandom;
      endcase
      if (i % 10 == 3) rb = '0;
      issue(rop, ra, rb, 1'b1);
    end

    // Abort at RUN cycle 10: no done, results from the previous op held
    issue(OP_DIV, $urandom, 32'd9, 1'b0);
    repeat (9) begin @(posedge clk_i); #1; end
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    check("abort_ready", 64'(ready_o), 64'd1);
    check("abort_hi_held", 64'(hi_o), 64'(last_hi));
    check("abort_lo_held", 64'(lo_o), 64'(last_lo));
    issue(OP_MUL, $urandom, $urandom, 1'b1);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin @(posedge clk_i); #1; n++; end
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
    end

    // Asynchronous reset in the middle of a run
    issue(OP_MUL, $urandom, $urandom, 1'b0);
    repeat (10) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    #1;
    check_reset_vals();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (40) begin @(posedge clk_i); #1; end
    check("post_reset_idle", 64'(ready_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
